// File: rtl/rv32i_ifetch.sv
// RV32I instruction fetch: sequential word requests, a credit-limited in-order
// instruction buffer, and redirect flush that drops in-flight wrong-path responses.
module rv32i_ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  entry_t mem [FIFO_DEPTH];

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   resp_pc_reg, resp_pc_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] drop_reg, drop_next;
  logic          req_valid_q, req_valid_next;
  logic          req_stale_q, req_stale_next;
  logic [31:0]   req_addr_q, req_addr_next;
  entry_t        head_reg, head_next, push_entry;

  logic          fire, pop, push, drop_resp, load;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_target;

  always_comb begin
    redirect_target = redirect_pc & 32'hFFFF_FFFC;
    fire            = req_valid_q & imem_req_ready;
    pop             = (count_reg != '0) & instr_ready;
    drop_resp       = imem_resp_valid & (drop_reg != '0);
    push            = imem_resp_valid & (drop_reg == '0) & ~redirect_valid;

    push_entry.data  = imem_resp_data;
    push_entry.pc    = resp_pc_reg;
    push_entry.fault = imem_resp_err;

    // A firing request is still counted: it becomes outstanding on this edge.
    credit_used = (CW+1)'(count_reg) + (CW+1)'(outstanding_reg) + (CW+1)'(req_valid_q);
    load        = (~req_valid_q | fire) & (credit_used < DEPTH_W) & ~redirect_valid;

    outstanding_next = outstanding_reg + CW'(fire) - CW'(imem_resp_valid);

    req_valid_next = req_valid_q;
    req_addr_next  = req_addr_q;
    req_stale_next = req_stale_q;
    fetch_pc_next  = fetch_pc_reg;
    if (load) begin
      req_valid_next = 1'b1;
      req_addr_next  = fetch_pc_reg;
      req_stale_next = 1'b0;
      fetch_pc_next  = fetch_pc_reg + 32'd4;
    end else if (fire) begin
      req_valid_next = 1'b0;
      req_stale_next = 1'b0;
    end else if (redirect_valid && req_valid_q) begin
      req_stale_next = 1'b1;
    end
    if (redirect_valid) begin
      fetch_pc_next = redirect_target;
    end

    if (redirect_valid) begin
      count_next   = '0;
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      drop_next    = outstanding_next;
      resp_pc_next = redirect_target;
      head_next    = '0;
    end else begin
      count_next   = count_reg + CW'(push) - CW'(pop);
      wr_ptr_next  = wr_ptr_reg + AW'(push);
      rd_ptr_next  = rd_ptr_reg + AW'(pop);
      drop_next    = drop_reg + CW'(fire & req_stale_q) - CW'(drop_resp);
      resp_pc_next = push ? resp_pc_reg + 32'd4 : resp_pc_reg;
      // New head is the incoming word when the buffer would otherwise drain.
      if (count_next == '0) begin
        head_next = '0;
      end else if (count_reg == '0 || (count_reg == CW'(1) && pop)) begin
        head_next = push_entry;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      req_valid_q     <= 1'b0;
      req_stale_q     <= 1'b0;
      req_addr_q      <= '0;
      head_reg        <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      req_valid_q     <= req_valid_next;
      req_stale_q     <= req_stale_next;
      req_addr_q      <= req_addr_next;
      head_reg        <= head_next;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign instr_valid    = (count_reg != '0);
  assign instr          = head_reg.data;
  assign instr_pc       = head_reg.pc;
  assign instr_fault    = head_reg.fault;

  // Buffered + in-flight + pending request never exceed the buffer size.
  assert property (@(posedge clk) disable iff (!rst_n) credit_used <= DEPTH_W);

endmodule

// File: tb/tb_rv32i_ifetch.sv
// Bench for rv32i_ifetch: in-order variable-latency memory model and a
// sequential-PC reference stream that restarts at each redirect target.
module tb_rv32i_ifetch;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;

  always #5 clk = ~clk;

  rv32i_ifetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_fault     (instr_fault)
  );

  int err_count   = 0;
  int check_count = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;
  mem_req_t mq[$];

  // stimulus knobs (percent, redirect in per mille)
  int          p_ready    = 100;
  int          p_iready   = 100;
  int          p_redirect = 0;
  int          lat_min    = 1;
  int          lat_max    = 1;
  bit          rst_drive  = 1'b0;
  bit          force_redirect = 1'b0;
  logic [31:0] force_target = '0;
  logic [31:0] data_key = '0;
  logic [31:0] err_addr = '0;
  bit          err_en   = 1'b0;
  bit          rand_err = 1'b0;

  // reference model state
  int          cyc = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] fire_log[$];
  logic [31:0] pop_log[$];
  bit          fault_log[$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ data_key;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (err_en && a == err_addr) || (rand_err && a[6:2] == 5'd9);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] log_at(input int idx, input bit use_pop);
    if (use_pop) return (idx < pop_log.size()) ? pop_log[idx] : 32'hDEAD_BEEF;
    return (idx < fire_log.size()) ? fire_log[idx] : 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive inputs at negedge, observe registered outputs,
  // and advance the model by what the coming posedge will do.
  task automatic step();
    bit          fire;
    bit          pop;
    bit          rdr;
    logic [31:0] tgt;
    mem_req_t    e;
    @(negedge clk);
    cyc++;
    rst_n          = rst_drive;
    imem_req_ready = (int'($urandom_range(99)) < p_ready);
    instr_ready    = (int'($urandom_range(99)) < p_iready);
    rdr            = force_redirect || (int'($urandom_range(999)) < p_redirect);
    tgt            = force_redirect ? force_target : $urandom;
    force_redirect = 1'b0;
    redirect_valid = rdr & rst_drive;
    redirect_pc    = tgt;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    imem_resp_err   = 1'($urandom);
    if (!rst_drive) begin
      mq.delete();
      exp_pc       = RESET_PC;
      prev_pending = 1'b0;
      return;
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = data_of(mq[0].addr);
      imem_resp_err   = err_of(mq[0].addr);
      mq.delete(0);
    end
    if (!instr_valid) begin
      check_eq("empty_instr", instr, 32'h0);
      check_eq("empty_pc", instr_pc, 32'h0);
      check_eq("empty_fault", 32'(instr_fault), 32'h0);
    end
    if (prev_pending) begin
      check_eq("hold_valid", 32'(imem_req_valid), 32'h1);
      check_eq("hold_addr", imem_req_addr, prev_addr);
    end
    fire = imem_req_valid && imem_req_ready;
    pop  = instr_valid && instr_ready;
    if (fire) begin
      e.addr = imem_req_addr;
      e.due  = cyc + int'($urandom_range(lat_max, lat_min));
      mq.push_back(e);
      fire_log.push_back(imem_req_addr);
    end
    if (pop) begin
      check_eq("instr_pc", instr_pc, exp_pc);
      check_eq("instr", instr, data_of(exp_pc));
      check_eq("instr_fault", 32'(instr_fault), 32'(err_of(exp_pc)));
      $display("[%0d] pop pc=%h instr=%h fault=%0d", cyc, instr_pc, instr, instr_fault);
      pop_log.push_back(instr_pc);
      fault_log.push_back(instr_fault);
      exp_pc = exp_pc + 32'd4;
    end
    if (rdr) begin
      exp_pc = tgt & 32'hFFFF_FFFC;
      $display("[%0d] redirect to %h", cyc, tgt);
    end
    prev_pending = imem_req_valid && !imem_req_ready;
    prev_addr    = imem_req_addr;
  endtask

  task automatic do_reset();
    rst_drive = 1'b0;
    repeat (3) step();
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check_eq("rst_req_addr", imem_req_addr, 32'h0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    check_eq("rst_instr_fault", 32'(instr_fault), 32'h0);
    rst_drive = 1'b1;
    step();
    fire_log.delete();
    pop_log.delete();
    fault_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_valid;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    imem_resp_err = 1'b0; instr_ready = 1'b0;

    // streaming from reset, latency 1, decode always ready
    do_reset();
    first_valid = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        check_eq("first_req_valid", 32'(imem_req_valid), 32'h1);
        check_eq("first_req_addr", imem_req_addr, RESET_PC);
      end
      if (instr_valid && first_valid == 0) first_valid = k;
    end
    check_eq("first_valid_by_cycle3", 32'(first_valid >= 1 && first_valid <= 3), 32'h1);
    check_eq("stream_rate", 32'(pop_log.size() >= 16), 32'h1);
    check_eq("stream_pc3", log_at(3, 1'b1), 32'hC);

    // credit limit: decode stalled
    p_iready = 0;
    do_reset();
    repeat (15) step();
    check_eq("credit_fires", 32'(fire_log.size()), 32'd4);
    check_eq("credit_last_addr", log_at(3, 1'b0), 32'hC);
    check_eq("credit_req_idle", 32'(imem_req_valid), 32'h0);
    check_eq("credit_full_valid", 32'(instr_valid), 32'h1);
    p_iready = 100;
    step();
    p_iready = 0;
    check_eq("credit_single_pop", 32'(pop_log.size()), 32'd1);
    repeat (8) step();
    check_eq("credit_refill_fires", 32'(fire_log.size()), 32'd5);
    check_eq("credit_refill_addr", log_at(4, 1'b0), 32'h10);

    // redirect with three requests in flight, latency 4
    p_iready = 100; lat_min = 4; lat_max = 4;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step();
      if (mq.size() == 3) break;
    end
    check_eq("inflight_3", 32'(mq.size()), 32'd3);
    check_eq("no_early_pop", 32'(pop_log.size()), 32'd0);
    force_redirect = 1'b1; force_target = 32'h100;
    step();
    pop_log.delete();
    repeat (20) step();
    check_eq("redirect_first_pc", log_at(0, 1'b1), 32'h100);

    // misaligned redirect target with the request register idle
    lat_min = 1; lat_max = 1; p_iready = 0;
    do_reset();
    repeat (12) step();
    check_eq("idle_before_redirect", 32'(imem_req_valid), 32'h0);
    force_redirect = 1'b1; force_target = 32'h102;
    step();
    fire_log.delete(); pop_log.delete();
    p_iready = 100;
    step();
    check_eq("flush_valid", 32'(instr_valid), 32'h0);
    repeat (10) step();
    check_eq("align_req_addr", log_at(0, 1'b0), 32'h100);
    check_eq("align_instr_pc", log_at(0, 1'b1), 32'h100);

    // pending request held across redirect, then dropped
    p_ready = 100;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      if (imem_req_valid && imem_req_addr == 32'h4) break;
    end
    p_ready = 0;
    step();
    check_eq("stale_req_addr", imem_req_addr, 32'h8);
    force_redirect = 1'b1; force_target = 32'h200;
    step();
    fire_log.delete(); pop_log.delete();
    repeat (2) step();
    p_ready = 100;
    repeat (12) step();
    check_eq("stale_fire0", log_at(0, 1'b0), 32'h8);
    check_eq("stale_fire1", log_at(1, 1'b0), 32'h200);
    check_eq("stale_first_pc", log_at(0, 1'b1), 32'h200);

    // bus error on 0x4
    err_en = 1'b1; err_addr = 32'h4;
    do_reset();
    repeat (10) step();
    check_eq("fault_pc1", log_at(1, 1'b1), 32'h4);
    check_eq("fault_at_4", 32'(fault_log.size() > 2 && fault_log[1]), 32'h1);
    check_eq("fault_clear_0", 32'(fault_log.size() > 2 && !fault_log[0]), 32'h1);
    check_eq("fault_clear_8", 32'(fault_log.size() > 2 && !fault_log[2]), 32'h1);
    err_en = 1'b0;

    // reset mid-stream with a full buffer
    p_iready = 0;
    do_reset();
    repeat (12) step();
    check_eq("pre_reset_full", 32'(instr_valid), 32'h1);
    rst_drive = 1'b0;
    repeat (2) step();
    check_eq("midreset_instr_valid", 32'(instr_valid), 32'h0);
    check_eq("midreset_req_valid", 32'(imem_req_valid), 32'h0);
    rst_drive = 1'b1;
    step();
    fire_log.delete(); pop_log.delete(); fault_log.delete();
    p_iready = 100;
    repeat (10) step();
    check_eq("refetch_addr", log_at(0, 1'b0), RESET_PC);
    check_eq("refetch_pc", log_at(0, 1'b1), RESET_PC);

    // randomized traffic
    data_key = 32'h1357_9BDF; rand_err = 1'b1;
    p_ready = 70; p_iready = 60; p_redirect = 30; lat_min = 1; lat_max = 5;
    do_reset();
    repeat (800) step();
    p_ready = 40; p_iready = 90; p_redirect = 60; lat_max = 3;
    repeat (600) step();
    check_eq("random_progress", 32'(pop_log.size() > 100), 32'h1);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
